vga_source_switch: RTL and testbench

//  Frame-synchronous N:1 VGA source selector. It replaces the combinational 2:1 RGB/sync mux.
//  A select request takes effect only at the next vsync start of the current source.

---
 rtl/vga_sw_pkg.sv | 23 ++
 rtl/vga_frame_edge.sv | 33 +++
 rtl/vga_source_switch.sv | 212 +++++++++++++++++++++
 tb/tb_vga_source_switch.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_sw_pkg.sv
// Shared types and helpers for the VGA source switch.
package vga_sw_pkg;

    // Switch controller states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        BLANK   = 2'd2
    } sw_state_e;

    // Sync polarity levels (value of SYNC_POL)
    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;

    // Width of the blank-frame counter (BLANK_FRAMES is 0..15)
    localparam int FCNT_W = 4;

    // Width of a source index; never narrower than one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_frame_edge.sv
// Frame-start detector: remembers the previous vsync level of the selected
// source and pulses when vsync enters its active level. On a source switch
// the history register is loaded from the new source so the change of
// source itself never looks like an edge.
module vga_frame_edge
    import vga_sw_pkg::*;
#(
    parameter bit SYNC_POL = SYNC_ACTIVE_LOW
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vs_cur,
    input  logic load,
    input  logic load_val,
    output logic frame_start
);

    logic prev_q, prev_d;

    // Next history value: new source's level on a switch, else current level
    always_comb begin
        prev_d = load ? load_val : vs_cur;
    end

    // History register, reset to the inactive sync level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= ~SYNC_POL;
        else        prev_q <= prev_d;
    end

    assign frame_start = (vs_cur == SYNC_POL) && (prev_q != SYNC_POL);

endmodule

// File: rtl/vga_source_switch.sv
// Frame-synchronous N:1 VGA source selector with post-switch blanking.
// A request is committed at the next frame start of the source currently
// shown; RGB is then held black for BLANK_FRAMES frames of the new source.
// Optional feature: define VGA_SW_TIMEOUT_EN to give up waiting for a frame
// boundary after TIMEOUT_CYC clocks (dead or unplugged source).
module vga_source_switch
    import vga_sw_pkg::*;
#(
    parameter int          N_SRC        = 4,
    parameter int          CW           = 4,
    parameter bit          SYNC_POL     = SYNC_ACTIVE_LOW,
    parameter int          BLANK_FRAMES = 1,
    parameter int unsigned TIMEOUT_CYC  = 2**22,
    localparam int         IW           = idx_w(N_SRC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IW-1:0]         sel_req,
    input  logic                  sel_valid,
    input  logic [N_SRC*CW-1:0]   r_in,
    input  logic [N_SRC*CW-1:0]   g_in,
    input  logic [N_SRC*CW-1:0]   b_in,
    input  logic [N_SRC-1:0]      hs_in,
    input  logic [N_SRC-1:0]      vs_in,
    output logic [CW-1:0]         r_out,
    output logic [CW-1:0]         g_out,
    output logic [CW-1:0]         b_out,
    output logic                  hs_out,
    output logic                  vs_out,
    output logic [IW-1:0]         sel_cur,
    output logic                  busy
);

    // Elaboration-time parameter sanity
    if (N_SRC < 2 || N_SRC > 16) begin : g_bad_nsrc
        $error("vga_source_switch: N_SRC must be 2..16");
    end
    if (BLANK_FRAMES < 0 || BLANK_FRAMES > 15) begin : g_bad_blank
        $error("vga_source_switch: BLANK_FRAMES must be 0..15");
    end
    if (TIMEOUT_CYC == 0) begin : g_bad_timeout
        $error("vga_source_switch: TIMEOUT_CYC must be non-zero");
    end

    sw_state_e           state_q, state_d;
    logic [IW-1:0]       sel_cur_q, sel_cur_d;
    logic [IW-1:0]       pend_q, pend_d;
    logic                pend_v_q, pend_v_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic [CW-1:0]       r_q, r_d, g_q, g_d, b_q, b_d;
    logic                hs_q, hs_d, vs_q, vs_d;

    logic                frame_start;
    logic                timeout;
    logic                do_switch;
    logic                req_ok;

    assign req_ok = sel_valid && (int'(sel_req) < N_SRC);

    vga_frame_edge #(.SYNC_POL(SYNC_POL)) u_frame_edge (
        .clk         (clk),
        .rst_n       (rst_n),
        .vs_cur      (vs_in[sel_cur_q]),
        .load        (do_switch),
        .load_val    (vs_in[pend_q]),
        .frame_start (frame_start)
    );

`ifdef VGA_SW_TIMEOUT_EN
    logic [31:0] tcnt_q, tcnt_d;

    assign timeout = (state_q != IDLE) && (tcnt_q == 32'(TIMEOUT_CYC - 1));

    // Clocks since the last frame boundary while a switch is in progress
    always_comb begin
        tcnt_d = tcnt_q + 32'd1;
        if (state_q == IDLE || frame_start || timeout) tcnt_d = '0;
    end

    // Timeout counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tcnt_q <= '0;
        else        tcnt_q <= tcnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    // Switch FSM: request filtering, frame-synchronous commit, blank count
    always_comb begin
        state_d   = state_q;
        sel_cur_d = sel_cur_q;
        pend_d    = pend_q;
        pend_v_d  = pend_v_q;
        fcnt_d    = fcnt_q;
        do_switch = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_ok && sel_req != sel_cur_q) begin
                    pend_d  = sel_req;
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (frame_start || timeout) begin
                    // Commit the old pend; a coincident request is applied
                    // as if it arrived in the state we move into.
                    do_switch = 1'b1;
                    sel_cur_d = pend_q;
                    fcnt_d    = '0;
                    pend_v_d  = 1'b0;
                    if (BLANK_FRAMES > 0) begin
                        state_d = BLANK;
                        if (req_ok) begin
                            if (sel_req == pend_q) begin
                                pend_v_d = 1'b0;
                            end else begin
                                pend_d   = sel_req;
                                pend_v_d = 1'b1;
                            end
                        end
                    end else begin
                        state_d = IDLE;
                        if (req_ok && sel_req != pend_q) begin
                            pend_d  = sel_req;
                            state_d = PENDING;
                        end
                    end
                end else if (req_ok) begin
                    if (sel_req == sel_cur_q) state_d = IDLE;
                    else                      pend_d  = sel_req;
                end
            end
            BLANK: begin
                // Requests are queued; asking for the shown source cancels
                if (req_ok) begin
                    if (sel_req == sel_cur_q) begin
                        pend_v_d = 1'b0;
                    end else begin
                        pend_d   = sel_req;
                        pend_v_d = 1'b1;
                    end
                end
                if (timeout ||
                    (frame_start && (int'(fcnt_q) + 1 >= BLANK_FRAMES))) begin
                    state_d  = pend_v_d ? PENDING : IDLE;
                    pend_v_d = 1'b0;
                end else if (frame_start) begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_cur_q <= '0;
            pend_q    <= '0;
            pend_v_q  <= 1'b0;
            fcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            sel_cur_q <= sel_cur_d;
            pend_q    <= pend_d;
            pend_v_q  <= pend_v_d;
            fcnt_q    <= fcnt_d;
        end
    end

    // Output mux from the current source; RGB forced black while blanking
    always_comb begin
        r_d  = r_in[int'(sel_cur_q)*CW +: CW];
        g_d  = g_in[int'(sel_cur_q)*CW +: CW];
        b_d  = b_in[int'(sel_cur_q)*CW +: CW];
        hs_d = hs_in[sel_cur_q];
        vs_d = vs_in[sel_cur_q];
        if (state_q == BLANK) begin
            r_d = '0;
            g_d = '0;
            b_d = '0;
        end
    end

    // Output registers; syncs reset to their inactive level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q  <= '0;
            g_q  <= '0;
            b_q  <= '0;
            hs_q <= ~SYNC_POL;
            vs_q <= ~SYNC_POL;
        end else begin
            r_q  <= r_d;
            g_q  <= g_d;
            b_q  <= b_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
        end
    end

    assign r_out   = r_q;
    assign g_out   = g_q;
    assign b_out   = b_q;
    assign hs_out  = hs_q;
    assign vs_out  = vs_q;
    assign sel_cur = sel_cur_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_vga_source_switch.sv
// Self-checking bench for vga_source_switch: four synthetic sources with
// staggered 200-clock frames, directed scenarios plus random requests,
// checked every cycle against a behavioural model of the switch rules.
module tb_vga_source_switch;

    localparam int N   = 4;
    localparam int CW  = 4;
    localparam int BF  = 1;
    localparam int TO  = 500;
    localparam int PER = 200;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      sel_req = '0;
    logic            sel_valid = 1'b0;
    logic [N*CW-1:0] r_in, g_in, b_in;
    logic [N-1:0]    hs_in, vs_in;
    logic [CW-1:0]   r_out, g_out, b_out;
    logic            hs_out, vs_out;
    logic [1:0]      sel_cur;
    logic            busy;

    always #5 clk = ~clk;

    vga_source_switch #(
        .N_SRC(N), .CW(CW), .SYNC_POL(1'b0), .BLANK_FRAMES(BF), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sel_req(sel_req), .sel_valid(sel_valid),
        .r_in(r_in), .g_in(g_in), .b_in(b_in), .hs_in(hs_in), .vs_in(vs_in),
        .r_out(r_out), .g_out(g_out), .b_out(b_out), .hs_out(hs_out),
        .vs_out(vs_out), .sel_cur(sel_cur), .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit vs_dead = 1'b0;

    // Behavioural model: mode 0 = idle, 1 = waiting for boundary, 2 = blanking
    int        m_mode, m_sel, m_pend, m_fcnt, m_tcnt;
    bit        m_pendv, m_prev;
    logic [3:0] e_r, e_g, e_b;
    bit        e_hs, e_vs;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int phase(input int k);
        return k * 50 + 7;
    endfunction

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            r_in[k*CW +: CW] = 4'(k + 1);
            g_in[k*CW +: CW] = 4'(k + 8);
            b_in[k*CW +: CW] = 4'(cyc + k);
            hs_in[k] = ((cyc + 3*k) % 20) < 2 ? 1'b0 : 1'b1;
            vs_in[k] = (vs_dead && k == 0) ? 1'b1
                     : (((cyc + phase(k)) % PER) < 4 ? 1'b0 : 1'b1);
        end
    endtask

    task automatic m_reset();
        m_mode = 0; m_sel = 0; m_pend = 0; m_pendv = 0; m_fcnt = 0; m_tcnt = 0;
        m_prev = 1; e_r = 0; e_g = 0; e_b = 0; e_hs = 1; e_vs = 1;
    endtask

    task automatic m_queue(input int rq);
        if (rq == m_sel) m_pendv = 0;
        else begin m_pend = rq; m_pendv = 1; end
    endtask

    // Advance the model by one clock using the inputs present at that edge
    task automatic model_step();
        bit fb, to, req;
        int rq;
        if (!rst_n) begin m_reset(); return; end
        req = sel_valid;
        rq  = int'(sel_req);
        fb  = (vs_in[m_sel] == 1'b0) && m_prev;
        to  = 0;
`ifdef VGA_SW_TIMEOUT_EN
        to = (m_mode != 0) && (m_tcnt == TO - 1);
        m_tcnt = (m_mode == 0 || fb || to) ? 0 : m_tcnt + 1;
`endif
        e_r  = (m_mode == 2) ? 4'd0 : r_in[m_sel*CW +: CW];
        e_g  = (m_mode == 2) ? 4'd0 : g_in[m_sel*CW +: CW];
        e_b  = (m_mode == 2) ? 4'd0 : b_in[m_sel*CW +: CW];
        e_hs = hs_in[m_sel];
        e_vs = vs_in[m_sel];
        m_prev = vs_in[m_sel];
        case (m_mode)
            0: if (req && rq != m_sel) begin m_pend = rq; m_mode = 1; end
            1: begin
                if (fb || to) begin
                    m_sel = m_pend; m_prev = vs_in[m_sel]; m_fcnt = 0; m_pendv = 0;
                    m_mode = 2;
                    if (req) m_queue(rq);
                end else if (req) begin
                    if (rq == m_sel) m_mode = 0;
                    else m_pend = rq;
                end
            end
            default: begin
                if (req) m_queue(rq);
                if (to || (fb && m_fcnt + 1 >= BF)) begin
                    m_mode = m_pendv ? 1 : 0;
                    m_pendv = 0;
                end else if (fb) m_fcnt++;
            end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_step();
        sel_valid = 1'b0;
        cyc++;
        drive();
    endtask

    task automatic req(input int v);
        sel_req = 2'(v);
        sel_valid = 1'b1;
        step();
    endtask

    task automatic wait_sel(input int v, input int bound, input string nm, output int n);
        n = 0;
        while (int'(sel_cur) != v && n < bound) begin step(); n++; end
        chk(nm, int'(sel_cur), v);
    endtask

    task automatic wait_idle(input int bound, input string nm);
        int n = 0;
        while (busy && n < bound) begin step(); n++; end
        chk(nm, int'(busy), 0);
    endtask

    task automatic wait_mid(input int src);
        while (((cyc + phase(src)) % PER) != 100) step();
    endtask

    task automatic wait_bnd(input int src);
        while (((cyc + phase(src)) % PER) != 0) step();
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        chk("r_out", int'(r_out), int'(e_r));
        chk("g_out", int'(g_out), int'(e_g));
        chk("b_out", int'(b_out), int'(e_b));
        chk("hs_out", int'(hs_out), int'(e_hs));
        chk("vs_out", int'(vs_out), int'(e_vs));
        chk("sel_cur", int'(sel_cur), m_sel);
        chk("busy", int'(busy), (m_mode != 0) ? 1 : 0);
    end

    initial begin
        int n;
        m_reset();
        drive();
        repeat (3) step();
        chk("rst hs_out", int'(hs_out), 1);
        chk("rst vs_out", int'(vs_out), 1);
        chk("rst r_out", int'(r_out), 0);
        chk("rst sel_cur", int'(sel_cur), 0);
        chk("rst busy", int'(busy), 0);
        rst_n = 1'b1;
        step();
        chk("src0 r", int'(r_out), 1);
        chk("src0 g", int'(g_out), 8);

        // Switch 0 -> 2 requested mid-frame
        wait_mid(0);
        req(2);
        chk("pending busy", int'(busy), 1);
        chk("pending sel", int'(sel_cur), 0);
        wait_sel(2, 300, "switch to 2", n);
        step();
        chk("blank r", int'(r_out), 0);
        chk("blank busy", int'(busy), 1);
        wait_idle(400, "blank end");
        step();
        chk("src2 r", int'(r_out), 3);

        // Latest request wins, then cancel by asking for the shown source
        wait_mid(2);
        req(1);
        repeat (5) step();
        req(3);
        wait_sel(3, 300, "latest wins", n);
        wait_idle(500, "idle after 3");
        wait_mid(3);
        req(0);
        repeat (5) step();
        req(3);
        chk("cancel busy", int'(busy), 0);
        repeat (250) step();
        chk("cancel no switch", int'(sel_cur), 3);

        // Request for the shown source while idle is ignored
        req(3);
        chk("same src busy", int'(busy), 0);

        // Request during blanking, then request coincident with a boundary
        wait_mid(3);
        req(1);
        wait_sel(1, 300, "switch to 1", n);
        repeat (3) step();
        req(2);
        chk("queued busy", int'(busy), 1);
        wait_sel(2, 800, "queued switch to 2", n);
        wait_idle(500, "idle after queued");
        wait_mid(2);
        req(0);
        wait_bnd(2);
        req(1);
        chk("coincident old pend", int'(sel_cur), 0);
        chk("coincident busy", int'(busy), 1);
        wait_sel(1, 800, "coincident honoured", n);
        wait_idle(500, "idle after coincident");

        // Random requests
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(39) == 0) begin
                sel_req = 2'($urandom_range(3));
                sel_valid = 1'b1;
            end
            step();
        end
        wait_idle(1500, "idle after random");
        if (sel_cur != 2'd0) begin
            req(0);
            wait_idle(1000, "back to 0");
        end

        // Dead source 0: wait for the boundary that never comes
        vs_dead = 1'b1;
        drive();
        req(2);
`ifdef VGA_SW_TIMEOUT_EN
        wait_sel(2, 600, "timeout switch", n);
        chk("timeout latency", n, TO);
        vs_dead = 1'b0;
        drive();
        wait_idle(600, "idle after timeout");
        wait_mid(2);
        req(1);
        repeat (3) step();
`else
        repeat (700) step();
        chk("no timeout sel", int'(sel_cur), 0);
        chk("no timeout busy", int'(busy), 1);
`endif
        // Reset while a switch is pending
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("midreset sel", int'(sel_cur), 0);
        chk("midreset busy", int'(busy), 0);
        chk("midreset hs", int'(hs_out), 1);
        repeat (3) step();
        rst_n = 1'b1;
        vs_dead = 1'b0;
        drive();
        repeat (300) step();
        chk("post reset sel", int'(sel_cur), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
